data_mem: RTL and testbench
===========================

Name: data_mem

Overview:
- Byte-addressable RV32I data memory for the pipeline MEM stage.
- Word-organised storage with RISC-V load/store width selection via funct3: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Reads are combinational. Writes are synchronous on the rising clock edge.
- Sits between the EX/MEM register (address, store data, control) and the MEM/WB register (load data).

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two.
- AW, 32, width of the byte address input.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears all storage.
- MemRead  input  1  load enable; data_out is valid only while high.
- MemWrite  input  1  store enable; sampled on the rising edge of clk.
- funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  AW  byte address; word index = addr[log2(DEPTH)+1:2], lane = addr[1:0].
- data_in  input  32  store data; the low byte or halfword is used for SB/SH.
- data_out  output  32  load result, sign- or zero-extended.

Behaviour:
- Storage: DEPTH x 32-bit words, little-endian byte lanes (lane 0 = bits 7:0).
- Address wrap: upper address bits above the index are ignored, so the word index wraps modulo DEPTH.
- Reset: while rst = 0, every word is cleared to 0 asynchronously, data_out = 0 and writes are blocked.
  - When rst deasserts, memory holds zeros.
  - Reset asserted mid-operation discards any pending write in that cycle.
- Read path: combinational, zero latency.
  - MemRead = 0: data_out = 0.
  - MemRead = 1, word W = mem[index], result by funct3:
    - 000: sign-extend byte W[8*lane+7 : 8*lane].
    - 001: sign-extend halfword W[16*addr[1]+15 : 16*addr[1]].
    - 010: W.
    - 100: zero-extend the byte.
    - 101: zero-extend the halfword.
    - 011, 110, 111: data_out = 0.
- Write path: on the rising clk edge with rst = 1 and MemWrite = 1, by funct3:
  - 000: write data_in[7:0] into byte lane addr[1:0] only.
  - 001: write data_in[15:0] into halfword addr[1] only.
  - 010: write all 32 bits.
  - Any other funct3: no write.
  - Bytes not selected are preserved.
- Misalignment (macro absent):
  - Halfword access ignores addr[0].
  - Word access ignores addr[1:0].
  - An access never spans two words.
- Simultaneous MemRead and MemWrite to the same word: data_out shows the old contents until the write edge, then the new contents (write-first is not required).
- No handshake: single-cycle access, no stall output.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_EN.
- When defined:
  - Extra output port misaligned (1 bit), combinational.
  - Asserted when (MemRead | MemWrite) is high and either:
    - funct3[1:0] = 01 and addr[0] = 1, or
    - funct3[1:0] = 10 and addr[1:0] != 00.
  - While misaligned is high, the store is suppressed and data_out = 0.
  - misaligned = 0 during reset.
- When undefined:
  - Port absent.
  - Low-offset-bit truncation applies as described under Behaviour.

Decomposition:
- Shared package data_mem_pkg holds:
  - funct3 constants F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101.
  - Default DEPTH = 64.
- One natural sub-module: data_mem_load_align. It is purely combinational: word + lane + funct3 -> extended 32-bit load value.
- Store lane-merge logic stays inline in data_mem.

Test Plan:
- Reset: drive rst = 0 after writes, release, then LW from addr 0x00, 0x04 and 0xFC -> 0x00000000 each.
- Word write/read: SW 0xDEADBEEF at addr 0x08; LW 0x08 -> 0xDEADBEEF; with MemRead = 0, data_out = 0.
- Byte/halfword stores: SW 0x00000000 at 0x10, then SB 0x..AB at 0x11 and SH 0x..1234 at 0x12; LW 0x10 -> 0x1234AB00.
- Sign/zero extension, with word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF; LHU 0x22 -> 0x000080FF.
  - LB 0x20 -> 0x00000001.
- Wrap and illegal funct3:
  - SW 0x11111111 at byte address 0x100 (DEPTH = 64); LW 0x000 -> 0x11111111.
  - Store with funct3 = 011 leaves the word unchanged.
  - Load with funct3 = 110 -> 0.
- Read-during-write: MemRead = MemWrite = 1 at 0x30 (old 0x5, new 0x9); data_out = 0x5 before the edge and 0x9 after. With DATA_MEM_MISALIGN_EN, SW at 0x31 raises misaligned and leaves memory unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the RV32I data memory.
// Optional misalignment detection is enabled by defining DATA_MEM_MISALIGN_EN.
package data_mem_pkg;

  localparam int DEPTH_DEFAULT = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane write enables for a store; unsupported widths write nothing.
  function automatic logic [3:0] store_byte_en(input logic [2:0] funct3,
                                               input logic [1:0] lane);
    case (funct3)
      F3_B:    return 4'b0001 << lane;
      F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Load-path lane selection and sign/zero extension for RV32I loads.
// Purely combinational; unsupported funct3 values produce zero.
module data_mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'b0, byte_sel};
      F3_HU:   data_o = {16'b0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable RV32I data memory: combinational loads, clocked stores.
// Define DATA_MEM_MISALIGN_EN to add the misaligned output and suppress misaligned accesses.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
`ifdef DATA_MEM_MISALIGN_EN
  output logic          misaligned,
`endif
  output logic [31:0]   data_out
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   load_val;
  logic [31:0]   wr_rep;
  logic [31:0]   word_d;
  logic [3:0]    byte_en;
  logic          mis_w;
  logic          unused_addr;

  // Upper address bits only select aliases of the same word.
  assign idx         = addr[IW+1:2];
  assign lane        = addr[1:0];
  assign unused_addr = ^addr[AW-1:IW+2];
  assign rd_word     = mem_q[idx];

`ifdef DATA_MEM_MISALIGN_EN
  assign mis_w = (MemRead | MemWrite) &
                 (((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
  assign misaligned = rst & mis_w;
`else
  assign mis_w = 1'b0;
`endif

  data_mem_load_align u_load_align (
    .word_i   (rd_word),
    .lane_i   (lane),
    .funct3_i (funct3),
    .data_o   (load_val)
  );

  assign data_out = (rst && MemRead && !mis_w) ? load_val : 32'h0;

  // Replicate the store operand so every lane sees its own byte of data_in.
  always_comb begin
    byte_en = store_byte_en(funct3, lane);
    wr_rep  = data_in;
    case (funct3)
      F3_B:    wr_rep = {4{data_in[7:0]}};
      F3_H:    wr_rep = {2{data_in[15:0]}};
      default: wr_rep = data_in;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_d[8*gi +: 8] = byte_en[gi] ? wr_rep[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemWrite && (byte_en != 4'b0000) && !mis_w) begin
      mem_q[idx] <= word_d;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
`ifdef DATA_MEM_MISALIGN_EN
  logic        misaligned;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  data_mem #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .funct3   (funct3),
    .addr     (addr),
    .data_in  (data_in),
`ifdef DATA_MEM_MISALIGN_EN
    .misaligned (misaligned),
`endif
    .data_out (data_out)
  );

  // ---------------- reference model ----------------
  function automatic bit model_mis(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [31:0] a);
`ifdef DATA_MEM_MISALIGN_EN
    return (rd || wr) && ((f3[1:0] == 2'b01 && a[0]) ||
                          (f3[1:0] == 2'b10 && a[1:0] != 2'b00));
`else
    return 1'b0 && rd && wr && (f3 == 3'b0) && (a == 32'h0);
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int unsigned base = ((a / 4) % DEPTH) * 4;
    int unsigned off  = a % 4;
    int unsigned hoff = (off / 2) * 2;
    logic [7:0]  b = ref_mem[base + off];
    logic [15:0] h = {ref_mem[base + hoff + 1], ref_mem[base + hoff]};
    logic [31:0] w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] d);
    int unsigned base = ((a / 4) % DEPTH) * 4;
    int unsigned off  = a % 4;
    int unsigned hoff = (off / 2) * 2;
    if (model_mis(1'b0, 1'b1, f3, a)) return;
    case (f3)
      3'd0: ref_mem[base + off] = d[7:0];
      3'd1: begin
        ref_mem[base + hoff]     = d[7:0];
        ref_mem[base + hoff + 1] = d[15:8];
      end
      3'd2: for (int i = 0; i < 4; i++) ref_mem[base + i] = d[8*i +: 8];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] expected_read(input logic rd, input logic wr,
                                                input logic [2:0] f3, input logic [31:0] a);
    if (!rd || model_mis(rd, wr, f3, a)) return 32'h0;
    return model_load(f3, a);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b1; funct3 = f3; addr = a; data_in = d;
    @(posedge clk);
    model_store(f3, a, d);
    #1 MemWrite = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] q);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = f3; addr = a;
    #1 q = data_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] q;
    logic [31:0] a_list [3];
    a_list[0] = 32'h00; a_list[1] = 32'h04; a_list[2] = 32'hFC;
    model_clear();
    MemRead = 1'b1; funct3 = F3_W; addr = 32'h0;
    #12;
    checks++;
    if (data_out !== 32'h0) $display("FAIL reset_hold_out got %h exp %h", data_out, 32'h0);
    else passes++;
    @(negedge clk) rst = 1'b1;
    foreach (a_list[i]) do_store(F3_W, a_list[i], 32'hA5A5A5A5);
    do_load(F3_W, 32'hFC, q);
    checks++;
    if (q !== 32'hA5A5A5A5) $display("FAIL reset_prewrite got %h exp %h", q, 32'hA5A5A5A5);
    else passes++;
    // Assert reset asynchronously while a write is pending across an edge.
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b1; funct3 = F3_W; addr = 32'h04; data_in = 32'h12345678;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0) $display("FAIL reset_async_out got %h exp %h", data_out, 32'h0);
    else passes++;
    @(posedge clk);
    @(negedge clk) MemWrite = 1'b0;
    rst = 1'b1;
    model_clear();
    foreach (a_list[i]) begin
      do_load(F3_W, a_list[i], q);
      checks++;
      if (q !== 32'h0) $display("FAIL reset_lw_%h got %h exp %h", a_list[i], q, 32'h0);
      else passes++;
    end
    $display("test_reset done");
  endtask

  task automatic test_word();
    logic [31:0] q;
    do_store(F3_W, 32'h08, 32'hDEADBEEF);
    do_load(F3_W, 32'h08, q);
    checks++;
    if (q !== 32'hDEADBEEF) $display("FAIL word_lw got %h exp %h", q, 32'hDEADBEEF);
    else passes++;
    @(negedge clk) MemRead = 1'b0;
    #1;
    checks++;
    if (data_out !== 32'h0) $display("FAIL word_noread got %h exp %h", data_out, 32'h0);
    else passes++;
    $display("test_word done");
  endtask

  task automatic test_byte_half();
    logic [31:0] q;
    do_store(F3_W, 32'h10, 32'h00000000);
    do_store(F3_B, 32'h11, 32'hFFFFFFAB);
    do_store(F3_H, 32'h12, 32'hEEEE1234);
    do_load(F3_W, 32'h10, q);
    checks++;
    if (q !== 32'h1234AB00) $display("FAIL byte_half_merge got %h exp %h", q, 32'h1234AB00);
    else passes++;
    $display("test_byte_half done");
  endtask

  task automatic test_extension();
    logic [31:0] q;
    logic [2:0]  f3s [5];
    logic [31:0] as  [5];
    logic [31:0] exps[5];
    f3s[0] = F3_B;  as[0] = 32'h23; exps[0] = 32'hFFFFFF80;
    f3s[1] = F3_BU; as[1] = 32'h23; exps[1] = 32'h00000080;
    f3s[2] = F3_H;  as[2] = 32'h22; exps[2] = 32'hFFFF80FF;
    f3s[3] = F3_HU; as[3] = 32'h22; exps[3] = 32'h000080FF;
    f3s[4] = F3_B;  as[4] = 32'h20; exps[4] = 32'h00000001;
    do_store(F3_W, 32'h20, 32'h80FF7F01);
    foreach (f3s[i]) begin
      do_load(f3s[i], as[i], q);
      checks++;
      if (q !== exps[i]) $display("FAIL ext_f3_%0d_addr_%h got %h exp %h", f3s[i], as[i], q, exps[i]);
      else passes++;
    end
    $display("test_extension done");
  endtask

  task automatic test_wrap_illegal();
    logic [31:0] q;
    do_store(F3_W, 32'h100, 32'h11111111);
    do_load(F3_W, 32'h000, q);
    checks++;
    if (q !== 32'h11111111) $display("FAIL wrap_lw got %h exp %h", q, 32'h11111111);
    else passes++;
    do_store(3'b011, 32'h000, 32'h22222222);
    do_load(F3_W, 32'h000, q);
    checks++;
    if (q !== 32'h11111111) $display("FAIL illegal_store got %h exp %h", q, 32'h11111111);
    else passes++;
    do_load(3'b110, 32'h000, q);
    checks++;
    if (q !== 32'h0) $display("FAIL illegal_load_110 got %h exp %h", q, 32'h0);
    else passes++;
    do_load(3'b111, 32'h000, q);
    checks++;
    if (q !== 32'h0) $display("FAIL illegal_load_111 got %h exp %h", q, 32'h0);
    else passes++;
    $display("test_wrap_illegal done");
  endtask

  task automatic test_rdw();
    logic [31:0] q;
    do_store(F3_W, 32'h30, 32'h5);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; funct3 = F3_W; addr = 32'h30; data_in = 32'h9;
    #1;
    checks++;
    if (data_out !== 32'h5) $display("FAIL rdw_before got %h exp %h", data_out, 32'h5);
    else passes++;
    @(posedge clk);
    model_store(F3_W, 32'h30, 32'h9);
    #1;
    checks++;
    if (data_out !== 32'h9) $display("FAIL rdw_after got %h exp %h", data_out, 32'h9);
    else passes++;
    MemWrite = 1'b0;
`ifdef DATA_MEM_MISALIGN_EN
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; funct3 = F3_W; addr = 32'h31; data_in = 32'hFFFFFFFF;
    #1;
    checks++;
    if (misaligned !== 1'b1) $display("FAIL mis_flag got %b exp %b", misaligned, 1'b1);
    else passes++;
    checks++;
    if (data_out !== 32'h0) $display("FAIL mis_data got %h exp %h", data_out, 32'h0);
    else passes++;
    @(posedge clk);
    #1 MemWrite = 1'b0;
    do_load(F3_W, 32'h30, q);
    checks++;
    if (q !== 32'h9) $display("FAIL mis_nowrite got %h exp %h", q, 32'h9);
    else passes++;
`else
    do_load(F3_H, 32'h31, q);
    checks++;
    if (q !== 32'h9) $display("FAIL half_truncate got %h exp %h", q, 32'h9);
    else passes++;
`endif
    $display("test_rdw done");
  endtask

  task automatic test_random();
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, d, exp_v;
    int          errs = 0;
    for (int n = 0; n < 300; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      d  = $urandom;
      @(negedge clk);
      MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; data_in = d;
      #1;
      exp_v = expected_read(rd, wr, f3, a);
      checks++;
      if (data_out !== exp_v) begin
        $display("FAIL rand_pre_%0d f3=%0d addr=%h got %h exp %h", n, f3, a, data_out, exp_v);
        errs++;
      end else passes++;
`ifdef DATA_MEM_MISALIGN_EN
      checks++;
      if (misaligned !== model_mis(rd, wr, f3, a)) begin
        $display("FAIL rand_mis_%0d got %b exp %b", n, misaligned, model_mis(rd, wr, f3, a));
        errs++;
      end else passes++;
`endif
      @(posedge clk);
      if (wr) model_store(f3, a, d);
      #1;
      exp_v = expected_read(rd, wr, f3, a);
      checks++;
      if (data_out !== exp_v) begin
        $display("FAIL rand_post_%0d f3=%0d addr=%h got %h exp %h", n, f3, a, data_out, exp_v);
        errs++;
      end else passes++;
    end
    @(negedge clk) MemWrite = 1'b0;
    $display("test_random done, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_extension();
    test_wrap_illegal();
    test_rdw();
    test_random();
    MemRead = 1'b0;
    MemWrite = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
